// File: rtl/fpga_test_pkg.sv
// Shared types and constants for the FPGA test-top checkers.
package fpga_test_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam int MemoryElementWidthDefault = 32'd12;

  // Sliced down to the index width by each user; all-ones means "no mismatch seen".
  localparam logic [31:0] NoMismatchAllOnes = 32'hFFFF_FFFF;

  function automatic int unsigned clamp_u(input int unsigned value, input int unsigned cap);
    return (value > cap) ? cap : value;
  endfunction

endpackage

// File: rtl/out_channel_checker_if.sv
// Executor out-channel: one word per cycle on valid/ready plus the completion level.
interface out_channel_checker_if #(
  parameter int MemoryElementWidth = fpga_test_pkg::MemoryElementWidthDefault
);
  logic                          outValid;
  logic [MemoryElementWidth-1:0] outData;
  logic                          outReady;
  logic                          programFinished;

  modport master (
    output outValid,
    output outData,
    output programFinished,
    input  outReady
  );

  modport slave (
    input  outValid,
    input  outData,
    input  programFinished,
    output outReady
  );
endinterface

// File: rtl/checker_expected_ram.sv
// Expected-value table: one synchronous write port, one asynchronous read port.
module checker_expected_ram #(
  parameter  int NOut  = 100,
  parameter  int Width = 12,
  localparam int AW    = $clog2(NOut),
  localparam int CW    = $clog2(NOut) + 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [CW-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [NOut];
  logic             wr_in_range;
  logic             rd_in_range;

  assign wr_in_range = (32'(waddr_i) < 32'(NOut));
  assign rd_in_range = (32'(raddr_i) < 32'(NOut));

  // Table contents are deliberately not reset so a rerun reuses them.
  always_ff @(posedge clk_i) begin
    if (we_i && wr_in_range) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads past the table return zero; the top never compares those words.
  always_comb begin
    rdata_o = {Width{1'b0}};
    if (rd_in_range) begin
      rdata_o = mem_q[raddr_i[AW-1:0]];
    end else begin
      rdata_o = {Width{1'b0}};
    end
  end

endmodule

// File: rtl/out_channel_checker.sv
// Captures the executor's out-channel stream, compares each word against the
// preloaded expected table and reports pass/fail once the run completes.
module out_channel_checker
  import fpga_test_pkg::*;
#(
  parameter  int MemoryElementWidth = MemoryElementWidthDefault,
  parameter  int NOut               = 100,
  parameter  int MaxSteps           = 1000,
  localparam int AW                 = $clog2(NOut),
  localparam int CW                 = $clog2(NOut) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          loadValid,
  input  logic [AW-1:0]                 loadAddr,
  input  logic [MemoryElementWidth-1:0] loadData,
  input  logic [CW-1:0]                 expectedCount,
  input  logic                          start,
  out_channel_checker_if.slave          out_ch,
  output logic                          finished,
  output logic                          success,
  output logic                          timedOut,
  output logic [CW-1:0]                 receivedCount,
  output logic [CW-1:0]                 firstMismatch
);

  localparam int            SW         = $clog2(MaxSteps + 1);
  localparam logic [CW-1:0] NoMismatch = NoMismatchAllOnes[CW-1:0];
  localparam logic [CW-1:0] SatCount   = CW'(NOut + 1);
  localparam logic [SW-1:0] StepsLast  = SW'(MaxSteps - 1);

  state_e                        state_q, state_d;
  logic [CW-1:0]                 limit_q, limit_d;
  logic [CW-1:0]                 rcv_q, rcv_d;
  logic [SW-1:0]                 steps_q, steps_d;
  logic                          err_q, err_d;
  logic [CW-1:0]                 mism_q, mism_d;
  logic                          fin_q, fin_d;
  logic                          succ_q, succ_d;
  logic                          to_q, to_d;

  logic                          ram_we;
  logic [MemoryElementWidth-1:0] ram_rdata;
  logic                          xfer;
  logic                          word_bad;
  logic                          leave_collect;

  checker_expected_ram #(
    .NOut  (NOut),
    .Width (MemoryElementWidth)
  ) u_table (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i (loadAddr),
    .wdata_i (loadData),
    .raddr_i (rcv_q),
    .rdata_o (ram_rdata)
  );

  assign out_ch.outReady = (state_q == StCollect);
  assign xfer            = out_ch.outValid && out_ch.outReady;
  assign leave_collect   = out_ch.programFinished || (steps_q == StepsLast);

  // Next-state and result computation; the word arriving this cycle is folded in before Done is judged.
  always_comb begin
    state_d  = state_q;
    limit_d  = limit_q;
    rcv_d    = rcv_q;
    steps_d  = steps_q;
    err_d    = err_q;
    mism_d   = mism_q;
    fin_d    = fin_q;
    succ_d   = succ_q;
    to_d     = to_q;
    ram_we   = 1'b0;
    word_bad = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        ram_we = (state_q == StIdle) && loadValid;
        if (start) begin
          state_d = StCollect;
          limit_d = CW'(clamp_u(32'(expectedCount), 32'(NOut)));
          rcv_d   = {CW{1'b0}};
          steps_d = {SW{1'b0}};
          err_d   = 1'b0;
          mism_d  = NoMismatch;
          fin_d   = 1'b0;
          succ_d  = 1'b0;
          to_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      StCollect: begin
        if (xfer) begin
          word_bad = (rcv_q >= limit_q) || (out_ch.outData != ram_rdata);
          err_d    = err_q || word_bad;
          mism_d   = (word_bad && (mism_q == NoMismatch)) ? rcv_q : mism_q;
          rcv_d    = (rcv_q == SatCount) ? rcv_q : (rcv_q + CW'(1));
        end else begin
          word_bad = 1'b0;
        end

        if (leave_collect) begin
          state_d = StDone;
          fin_d   = 1'b1;
          // Completion wins over a budget expiry landing in the same cycle.
          to_d    = !out_ch.programFinished;
          succ_d  = !err_d && (rcv_d == limit_q) && out_ch.programFinished;
          mism_d  = ((mism_d == NoMismatch) && (rcv_d < limit_q)) ? rcv_d : mism_d;
        end else begin
          steps_d = steps_q + SW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and result registers with synchronous reset; the table itself is kept.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      limit_q <= {CW{1'b0}};
      rcv_q   <= {CW{1'b0}};
      steps_q <= {SW{1'b0}};
      err_q   <= 1'b0;
      mism_q  <= NoMismatch;
      fin_q   <= 1'b0;
      succ_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      rcv_q   <= rcv_d;
      steps_q <= steps_d;
      err_q   <= err_d;
      mism_q  <= mism_d;
      fin_q   <= fin_d;
      succ_q  <= succ_d;
      to_q    <= to_d;
    end
  end

  assign finished      = fin_q;
  assign success       = succ_q;
  assign timedOut      = to_q;
  assign receivedCount = rcv_q;
  assign firstMismatch = mism_q;

endmodule

// File: tb/tb_out_channel_checker.sv
// Scoreboard bench for out_channel_checker: a word-list reference model predicts each run's verdict.
module tb_out_channel_checker;

  localparam int W     = 12;
  localparam int NOUT  = 10;
  localparam int MAXS  = 16;
  localparam int AW    = $clog2(NOUT);
  localparam int CW    = $clog2(NOUT) + 1;
  localparam int SLOTS = 32;
  localparam logic [CW-1:0] ALL1 = '1;

  typedef struct {
    logic          to;
    logic          succ;
    logic [CW-1:0] rcv;
    logic [CW-1:0] mm;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          loadValid = 1'b0;
  logic [AW-1:0] loadAddr = '0;
  logic [W-1:0]  loadData = '0;
  logic [CW-1:0] expectedCount = '0;
  logic          start = 1'b0;
  logic          finished, success, timedOut;
  logic [CW-1:0] receivedCount, firstMismatch;

  out_channel_checker_if #(.MemoryElementWidth(W)) ch ();

  out_channel_checker #(
    .MemoryElementWidth (W),
    .NOut               (NOUT),
    .MaxSteps           (MAXS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .loadValid     (loadValid),
    .loadAddr      (loadAddr),
    .loadData      (loadData),
    .expectedCount (expectedCount),
    .start         (start),
    .out_ch        (ch),
    .finished      (finished),
    .success       (success),
    .timedOut      (timedOut),
    .receivedCount (receivedCount),
    .firstMismatch (firstMismatch)
  );

  always #5 clock = ~clock;

  int       n_checks = 0;
  int       n_fail   = 0;
  bit       in_idle  = 1'b0;
  logic [W-1:0] exp_tbl [NOUT];
  bit       stim_v [SLOTS];
  logic [W-1:0] stim_d [SLOTS];
  bit       stim_f [SLOTS];
  exp_t     exp_q [$];
  logic     fin_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each rising edge of finished consumes one predicted verdict.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (finished === 1'b1 && fin_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: finished rose with no run outstanding (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("timedOut", timedOut, e.to);
        check("success", success, e.succ);
        check("receivedCount", receivedCount, e.rcv);
        check("firstMismatch", firstMismatch, e.mm);
      end
    end
    fin_prev <= finished;
  end

  // Reference: walk the accepted words in order against the expected table.
  function automatic void model(input int cnt, output exp_t e, output int endc);
    int lim, n, first, rcv;
    bit err, to, bad;
    lim = (cnt > NOUT) ? NOUT : cnt;
    n = 0; first = -1; err = 0; to = 1; endc = MAXS - 1;
    for (int c = 0; c < MAXS; c++) begin
      if (stim_v[c]) begin
        if (n >= lim) bad = 1;
        else bad = (stim_d[c] != exp_tbl[n]);
        if (bad && first < 0) first = n;
        err = err | bad;
        n++;
      end
      if (stim_f[c]) begin
        to = 0;
        endc = c;
        break;
      end
    end
    rcv = (n > NOUT + 1) ? NOUT + 1 : n;
    if (first < 0 && rcv < lim) first = rcv;
    e.to   = to;
    e.succ = !err && (rcv == lim) && !to;
    e.rcv  = CW'(rcv);
    e.mm   = (first < 0) ? ALL1 : CW'(first);
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < SLOTS; c++) begin
      stim_v[c] = 0; stim_d[c] = '0; stim_f[c] = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    in_idle = 1'b1;
    exp_q.delete();
  endtask

  task automatic load(input int addr, input logic [W-1:0] data);
    loadValid = 1'b1; loadAddr = AW'(addr); loadData = data;
    @(posedge clock); #1;
    loadValid = 1'b0;
    if (in_idle && addr < NOUT) exp_tbl[addr] = data;
  endtask

  task automatic run_stream(input int cnt, input bit ls_en, input int ls_addr, input logic [W-1:0] ls_data);
    exp_t e;
    int endc;
    if (ls_en && in_idle && ls_addr < NOUT) exp_tbl[ls_addr] = ls_data;
    model(cnt, e, endc);
    exp_q.push_back(e);
    start = 1'b1; expectedCount = CW'(cnt);
    loadValid = ls_en; loadAddr = AW'(ls_addr); loadData = ls_data;
    @(posedge clock); #1;
    start = 1'b0; loadValid = 1'b0; in_idle = 1'b0;
    for (int c = 0; c <= endc; c++) begin
      ch.outValid = stim_v[c]; ch.outData = stim_d[c]; ch.programFinished = stim_f[c];
      @(negedge clock);
      if (c == 0) check("ready_collect", ch.outReady, 1'b1);
      if (c == endc) check("finished_early", finished, 1'b0);
      @(posedge clock); #1;
    end
    ch.outValid = 1'b0; ch.programFinished = 1'b0;
    @(negedge clock);
    check("finished_on_time", finished, 1'b1);
    check("ready_done", ch.outReady, 1'b0);
    @(posedge clock); #1;
    check("scoreboard_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic gen_random();
    int fin_at, n;
    clear_stim();
    fin_at = $urandom_range(0, MAXS + 3);
    n = 0;
    for (int c = 0; c < MAXS; c++) begin
      if ($urandom_range(0, 9) < 7) begin
        stim_v[c] = 1;
        stim_d[c] = (n < NOUT && $urandom_range(0, 3) != 0) ? exp_tbl[n] : W'($urandom);
        n++;
      end
      stim_f[c] = (c == fin_at);
    end
  endtask

  initial begin
    ch.outValid = 1'b0; ch.outData = '0; ch.programFinished = 1'b0;
    do_reset();
    @(negedge clock);
    check("rst_finished", finished, 1'b0);
    check("rst_success", success, 1'b0);
    check("rst_timedOut", timedOut, 1'b0);
    check("rst_receivedCount", receivedCount, 0);
    check("rst_firstMismatch", firstMismatch, ALL1);
    check("rst_outReady", ch.outReady, 1'b0);
    @(posedge clock); #1;
    for (int a = 0; a < NOUT; a++) load(a, W'($urandom));

    // Single correct word.
    load(0, 12'd2);
    clear_stim(); stim_v[0] = 1; stim_d[0] = 12'd2; stim_f[1] = 1;
    run_stream(1, 0, 0, '0);
    // Loads in Done are ignored; rerun the same stream.
    load(0, 12'd7);
    run_stream(1, 0, 0, '0);
    // Wrong value on a rerun.
    clear_stim(); stim_v[0] = 1; stim_d[0] = 12'd3; stim_f[1] = 1;
    run_stream(1, 0, 0, '0);

    // Short stream.
    do_reset();
    load(0, 12'd5); load(1, 12'd7);
    clear_stim(); stim_v[0] = 1; stim_d[0] = 12'd5; stim_f[2] = 1;
    run_stream(2, 0, 0, '0);

    // Extra word arriving together with programFinished.
    do_reset();
    load(0, 12'd2);
    clear_stim(); stim_v[0] = 1; stim_d[0] = 12'd2; stim_v[1] = 1; stim_d[1] = 12'd9; stim_f[1] = 1;
    run_stream(1, 0, 0, '0);

    // Budget expiry.
    clear_stim(); stim_v[0] = 1; stim_d[0] = 12'd2;
    run_stream(1, 0, 0, '0);

    // Count clamp and receivedCount saturation.
    do_reset();
    for (int a = 0; a < NOUT; a++) load(a, W'(a * 3 + 1));
    clear_stim();
    for (int c = 0; c < 12; c++) begin stim_v[c] = 1; stim_d[c] = (c < NOUT) ? exp_tbl[c] : 12'd0; end
    stim_f[12] = 1;
    run_stream(15, 0, 0, '0);
    clear_stim();
    for (int c = 0; c < NOUT; c++) begin stim_v[c] = 1; stim_d[c] = exp_tbl[c]; end
    stim_f[NOUT] = 1;
    run_stream(15, 0, 0, '0);

    // Load performed in the same cycle as start.
    do_reset();
    clear_stim();
    for (int c = 0; c < 3; c++) begin stim_v[c] = 1; stim_d[c] = exp_tbl[c]; end
    stim_v[3] = 1; stim_d[3] = 12'hABC; stim_f[4] = 1;
    run_stream(4, 1, 3, 12'hABC);

    // Reset mid-Collect, then rerun with the retained table.
    do_reset();
    load(0, 12'd2); load(1, 12'd4);
    start = 1'b1; expectedCount = CW'(2);
    @(posedge clock); #1;
    start = 1'b0; ch.outValid = 1'b1; ch.outData = 12'd2;
    @(posedge clock); #1;
    ch.outValid = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_finished", finished, 1'b0);
    check("mid_rst_success", success, 1'b0);
    check("mid_rst_timedOut", timedOut, 1'b0);
    check("mid_rst_receivedCount", receivedCount, 0);
    check("mid_rst_firstMismatch", firstMismatch, ALL1);
    check("mid_rst_outReady", ch.outReady, 1'b0);
    @(posedge clock); #1;
    in_idle = 1'b1;
    clear_stim(); stim_v[0] = 1; stim_d[0] = 12'd2; stim_v[1] = 1; stim_d[1] = 12'd4; stim_f[2] = 1;
    run_stream(2, 0, 0, '0);

    // Randomized runs: reruns from Done mixed with fresh reloads.
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_reset();
        for (int k = 0; k < 4; k++) load($urandom_range(0, 15), W'($urandom));
      end
      gen_random();
      run_stream($urandom_range(0, 12), 0, 0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
